// File: rtl/dct_quant_zigzag.sv
`default_nettype none
// ============================================================================
// dct_quant_zigzag : ping-pong 8x8 coefficient buffer, quantize, zigzag out
// Revision: 1.0
// ============================================================================
module dct_quant_zigzag #(
  parameter int W_IN        = 16,
  parameter int W_Q         = 12,
  parameter int QSHIFT_BASE = 2,
  parameter int QSHIFT_MAX  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] z0,
  input  logic [W_IN-1:0] z1,
  input  logic [W_IN-1:0] z2,
  input  logic [W_IN-1:0] z3,
  input  logic [W_IN-1:0] z4,
  input  logic [W_IN-1:0] z5,
  input  logic [W_IN-1:0] z6,
  input  logic [W_IN-1:0] z7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W_Q-1:0]  out_coef,
  output logic [5:0]      out_idx,
  output logic            out_last
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  localparam logic [W_IN+1:0] QMAX = (W_IN+2)'((1 << (W_Q-1)) - 1);

  state_t              state_q, state_d;
  logic [1:0]          full_q, full_d;
  logic                wbank_q, wbank_d;
  logic                rbank_q, rbank_d;
  logic [2:0]          wrow_q, wrow_d;
  logic [5:0]          k_q, k_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [W_Q-1:0]      out_coef_q, out_coef_d;

  logic [W_IN-1:0]     bank_mem [2][64];
  logic [7:0][W_IN-1:0] row_w;
  logic                wr_fire;
  logic                load;
  logic                rd_bank;
  logic [5:0]          rd_k;

  // Symmetric round-half-away-from-zero on the magnitude, then saturate.
  function automatic logic [W_Q-1:0] quantize(input logic [W_IN-1:0] v,
                                               input logic [5:0]      addr);
    int              s;
    logic [W_IN+1:0] mag;
    logic [W_IN+1:0] half;
    logic [W_IN+1:0] rnd;
    logic [W_Q-1:0]  m;
    s = QSHIFT_BASE + ((int'(addr[5:3]) + int'(addr[2:0])) >> 2);
    if (s > QSHIFT_MAX) s = QSHIFT_MAX;
    mag  = v[W_IN-1] ? -{{2{v[W_IN-1]}}, v} : {2'b00, v};
    half = (s > 0) ? ((W_IN+2)'(1) << (s - 1)) : '0;
    rnd  = (mag + half) >> s;
    m    = (rnd > QMAX) ? QMAX[W_Q-1:0] : rnd[W_Q-1:0];
    return v[W_IN-1] ? -m : m;
  endfunction

  assign row_w     = {z7, z6, z5, z4, z3, z2, z1, z0};
  assign in_ready  = !full_q[wbank_q];
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_idx   = k_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wrow_d      = wrow_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_coef_d  = out_coef_q;
    load        = 1'b0;
    rd_bank     = rbank_q;
    rd_k        = k_q;

    if (wr_fire) begin
      wrow_d = wrow_q + 3'd1;
      if (wrow_q == 3'd7) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = S_SEND;
          load    = 1'b1;
          rd_k    = 6'd0;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (k_q == 6'd63) begin
            // Release this bank; chain straight into the other one if it is already full.
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
            rd_bank         = !rbank_q;
            rd_k            = 6'd0;
            if (full_q[!rbank_q]) begin
              load = 1'b1;
            end else begin
              state_d     = S_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end else begin
            load = 1'b1;
            rd_k = k_q + 6'd1;
          end
        end
      end
    endcase

    k_d = rd_k;
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = (rd_k == 6'd63);
      out_coef_d  = quantize(bank_mem[rd_bank][ZZ[rd_k]], ZZ[rd_k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      full_q      <= 2'b00;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wrow_q      <= 3'd0;
      k_q         <= 6'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_coef_q  <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wrow_q      <= wrow_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_coef_q  <= out_coef_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        bank_mem[wbank_q][{wrow_q, 3'(c)}] <= row_w[c];
      end
    end
  end

endmodule
`default_nettype wire
